// File: rtl/hdc_sample_sched.sv
// rtl/hdc_sample_sched.sv - ADC sample sequencer in front of the feature encoder with warm-up suppression.
// Optional overrun counter (OvrCnt_DO / OvrClr_SI) enabled by SCHED_OVERRUN_CNT_EN.
module hdc_sample_sched #(
  parameter int RAW_W      = 16,
  parameter int N_CH       = 4,
  parameter int CH_W       = 6,
  parameter int SBUF_DEPTH = 64,
  parameter int WCNT_W     = 16
) (
  input  logic                   Clk_CI,
  input  logic                   Reset_RBI,
  input  logic                   Enable_SI,
  input  logic                   SampleValid_SI,
  input  logic [RAW_W*N_CH-1:0]  Sample_DI,
  output logic                   EncValid_SO,
  input  logic                   EncReady_SI,
  output logic [RAW_W*N_CH-1:0]  EncRaw_DO,
  input  logic                   EncFeatValid_SI,
  output logic                   EncFeatReady_SO,
  input  logic [CH_W*N_CH-1:0]   EncChannels_DI,
  output logic                   OutValid_SO,
  input  logic                   OutReady_SI,
  output logic [CH_W*N_CH-1:0]   OutChannels_DO,
  output logic                   Overrun_SO,
  output logic [WCNT_W-1:0]      WinCnt_DO,
  output logic                   Busy_SO
`ifdef SCHED_OVERRUN_CNT_EN
  ,
  input  logic                   OvrClr_SI,
  output logic [15:0]            OvrCnt_DO
`endif
);

  localparam int WARM_W = $clog2(SBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    hold_full_q;
  logic [RAW_W*N_CH-1:0]   hold_data_q;
  logic [WARM_W-1:0]       warm_cnt_q;
  logic                    warm_done_q;
  logic [WCNT_W-1:0]       win_cnt_q;
  logic                    ovr_q;

  logic accepting, enc_xfer, load, drop, warm_hit, fwd, out_xfer;

  assign accepting = (state_q == WARMUP) || (state_q == RUN);
  assign enc_xfer  = EncValid_SO && EncReady_SI;
  assign load      = accepting && SampleValid_SI && (!hold_full_q || enc_xfer);
  assign drop      = accepting && SampleValid_SI && hold_full_q && !enc_xfer;
  // Warm-up transfers keep counting in DRAIN so a drained warm-up resumes where it left off.
  assign warm_hit  = !warm_done_q && enc_xfer && (warm_cnt_q == WARM_W'(SBUF_DEPTH - 1));
  assign fwd       = (state_q == RUN) || ((state_q == DRAIN) && warm_done_q);
  assign out_xfer  = OutValid_SO && OutReady_SI;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Enable_SI) state_d = warm_done_q ? RUN : WARMUP;
      WARMUP:  if (!Enable_SI) state_d = DRAIN;
               else if (warm_hit) state_d = RUN;
      RUN:     if (!Enable_SI) state_d = DRAIN;
      DRAIN:   if (!hold_full_q && !EncFeatValid_SI && EncReady_SI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    EncValid_SO     = hold_full_q && (state_q != IDLE);
    EncRaw_DO       = hold_data_q;
    OutValid_SO     = fwd && EncFeatValid_SI;
    OutChannels_DO  = fwd ? EncChannels_DI : '0;
    EncFeatReady_SO = fwd ? OutReady_SI : ((state_q == WARMUP) || (state_q == DRAIN));
    Busy_SO         = (state_q != IDLE);
    Overrun_SO      = ovr_q;
    WinCnt_DO       = win_cnt_q;
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      warm_cnt_q  <= '0;
      warm_done_q <= 1'b0;
      win_cnt_q   <= '0;
      ovr_q       <= 1'b0;
    end else begin
      if (load) begin
        hold_full_q <= 1'b1;
        hold_data_q <= Sample_DI;
      end else if (enc_xfer) begin
        hold_full_q <= 1'b0;
      end
      if (!warm_done_q && enc_xfer) warm_cnt_q <= warm_cnt_q + WARM_W'(1);
      if (warm_hit) warm_done_q <= 1'b1;
      if (out_xfer) win_cnt_q <= win_cnt_q + WCNT_W'(1);
      ovr_q <= drop;
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI)              ovr_cnt_q <= '0;
    else if (OvrClr_SI)          ovr_cnt_q <= drop ? 16'd1 : 16'd0;
    else if (drop && ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
  end

  assign OvrCnt_DO = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_hdc_sample_sched.sv
// tb/tb_hdc_sample_sched.sv - scoreboard bench for hdc_sample_sched (SCHED_OVERRUN_CNT_EN optional).
module tb_hdc_sample_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        samp_valid = 1'b0;
  logic [63:0] samp = '0;
  logic        enc_valid;
  logic        enc_ready = 1'b0;
  logic [63:0] enc_raw;
  logic        feat_valid = 1'b0;
  logic        feat_ready;
  logic [23:0] enc_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_ch;
  logic        overrun;
  logic [15:0] win_cnt;
  logic        busy;
`ifdef SCHED_OVERRUN_CNT_EN
  logic        ovr_clr = 1'b0;
  logic [15:0] ovr_cnt;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int xfer_cnt = 0;
  int out_seen = 0;
  logic [63:0] samp_q[$];
  logic [23:0] feat_q[$];

  hdc_sample_sched dut (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Enable_SI(enable),
    .SampleValid_SI(samp_valid), .Sample_DI(samp),
    .EncValid_SO(enc_valid), .EncReady_SI(enc_ready), .EncRaw_DO(enc_raw),
    .EncFeatValid_SI(feat_valid), .EncFeatReady_SO(feat_ready), .EncChannels_DI(enc_ch),
    .OutValid_SO(out_valid), .OutReady_SI(out_ready), .OutChannels_DO(out_ch),
    .Overrun_SO(overrun), .WinCnt_DO(win_cnt), .Busy_SO(busy)
`ifdef SCHED_OVERRUN_CNT_EN
    , .OvrClr_SI(ovr_clr), .OvrCnt_DO(ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle; the transfer itself happens on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (enc_valid && enc_ready) begin
        logic [63:0] exp_raw;
        xfer_cnt++;
        n_checks++;
        if (samp_q.size() == 0) $display("FAIL enc_xfer_unexpected: got %h want none", enc_raw);
        else begin
          exp_raw = samp_q.pop_front();
          if (enc_raw !== exp_raw) $display("FAIL enc_raw: got %h want %h", enc_raw, exp_raw);
          else n_pass++;
        end
      end
      if (out_valid) out_seen++;
      if (out_valid && out_ready) begin
        logic [23:0] exp_ch;
        n_checks++;
        if (feat_q.size() == 0) $display("FAIL out_xfer_unexpected: got %h want none", out_ch);
        else begin
          exp_ch = feat_q.pop_front();
          if (out_ch !== exp_ch) $display("FAIL out_channels: got %h want %h", out_ch, exp_ch);
          else n_pass++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] s, input bit accepted);
    samp_valid = 1'b1;
    samp = s;
    if (accepted) samp_q.push_back(s);
    cyc(1);
    samp_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit pulse_feat);
    for (int i = 0; i < n; i++) begin
      send({$urandom, $urandom}, 1'b1);
      if (pulse_feat && (i == 5 || i == 40)) begin
        feat_valid = 1'b1;
        enc_ch = 24'($urandom);
      end
      cyc(1);
      feat_valid = 1'b0;
      cyc(2);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    n_checks++;
    if ({busy, enc_valid, out_valid, feat_ready, overrun} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, enc_valid, out_valid, feat_ready, overrun});
    else n_pass++;
    n_checks++;
    if ({win_cnt, enc_raw, out_ch} !== '0) $display("FAIL reset_data: got %h want 0", {win_cnt, enc_raw, out_ch});
    else n_pass++;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_warmup;
    enable = 1'b1; enc_ready = 1'b1; out_ready = 1'b0;
    xfer_cnt = 0; out_seen = 0;
    cyc(1);
    feed(63, 1'b1);
    n_checks++;
    if (feat_ready !== 1'b1) $display("FAIL warm_63_featready: got %b want 1", feat_ready);
    else n_pass++;
    feed(1, 1'b0);
    n_checks++;
    if (xfer_cnt !== 64) $display("FAIL warm_xfers: got %0d want 64", xfer_cnt);
    else n_pass++;
    n_checks++;
    if (feat_ready !== 1'b0 || busy !== 1'b1) $display("FAIL warm_run_state: got rdy=%b busy=%b want 0 1", feat_ready, busy);
    else n_pass++;
    n_checks++;
    if (out_seen !== 0) $display("FAIL warm_outvalid: got %0d want 0", out_seen);
    else n_pass++;
    n_checks++;
    if (win_cnt !== 16'd0) $display("FAIL warm_wincnt: got %0d want 0", win_cnt);
    else n_pass++;
  endtask

  task automatic test_run_backpressure;
    logic [23:0] v;
    v = {6'h3F, 6'h01, 6'h20, 6'h00};
    feat_valid = 1'b1; enc_ch = v; out_ready = 1'b0;
    feat_q.push_back(v);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || feat_ready !== out_ready || out_ch !== v)
        $display("FAIL bp_cycle%0d: got v=%b r=%b ch=%h want 1 %b %h", k, out_valid, feat_ready, out_ch, out_ready, v);
      else n_pass++;
      cyc(1);
    end
    feat_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (win_cnt !== 16'd1) $display("FAIL bp_wincnt: got %0d want 1", win_cnt);
    else n_pass++;
  endtask

  task automatic test_overrun;
    logic [63:0] a;
    a = 64'hA1A1_0000_1111_2222;
    enc_ready = 1'b0;
    send(a, 1'b1);
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL ovr_first: got %b want 0", overrun);
    else n_pass++;
    cyc(1);
    send(64'hB2B2_3333_4444_5555, 1'b0);
    n_checks++;
    if (overrun !== 1'b1 || enc_raw !== a) $display("FAIL ovr_pulse: got %b %h want 1 %h", overrun, enc_raw, a);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (overrun !== 1'b0 || enc_valid !== 1'b1 || enc_raw !== a)
      $display("FAIL ovr_after: got %b %b %h want 0 1 %h", overrun, enc_valid, enc_raw, a);
    else n_pass++;
    enc_ready = 1'b1;
    cyc(1);
    n_checks++;
    if (enc_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", enc_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] d;
    d = 64'hD00D_D00D_1234_5678;
    enc_ready = 1'b0;
    send(64'hC0C0_C0C0_0000_0001, 1'b1);
    enc_ready = 1'b1;
    send(d, 1'b1);
    n_checks++;
    if (overrun !== 1'b0 || enc_valid !== 1'b1 || enc_raw !== d)
      $display("FAIL b2b_reload: got %b %b %h want 0 1 %h", overrun, enc_valid, enc_raw, d);
    else n_pass++;
    cyc(2);
  endtask

  task automatic test_drain;
    logic [63:0] e;
    e = 64'hEEEE_0000_EEEE_0001;
    enc_ready = 1'b0;
    send(e, 1'b1);
    enable = 1'b0;
    cyc(1);
    send(64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    cyc(2);
    n_checks++;
    if (busy !== 1'b1 || enc_valid !== 1'b1 || enc_raw !== e)
      $display("FAIL drain_hold: got %b %b %h want 1 1 %h", busy, enc_valid, enc_raw, e);
    else n_pass++;
    enc_ready = 1'b1;
    cyc(1);
    n_checks++;
    if (busy !== 1'b1 || enc_valid !== 1'b0) $display("FAIL drain_after_xfer: got %b %b want 1 0", busy, enc_valid);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL drain_idle: got %b want 0", busy);
    else n_pass++;
    enable = 1'b1; out_ready = 1'b0;
    cyc(1);
    n_checks++;
    if (busy !== 1'b1 || feat_ready !== 1'b0) $display("FAIL drain_rerun: got %b %b want 1 0", busy, feat_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    samp_q.delete();
    enable = 1'b1; enc_ready = 1'b1; out_ready = 1'b0;
    cyc(1);
    feed(30, 1'b0);
    enc_ready = 1'b0;
    send(64'h6666_7777_8888_9999, 1'b1);
    n_checks++;
    if (enc_valid !== 1'b1 || feat_ready !== 1'b1) $display("FAIL ar_pre: got %b %b want 1 1", enc_valid, feat_ready);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, enc_valid, feat_ready, overrun} !== 4'b0 || enc_raw !== '0 || win_cnt !== '0)
      $display("FAIL ar_clear: got %b %h %h want 0", {busy, enc_valid, feat_ready, overrun}, enc_raw, win_cnt);
    else n_pass++;
    samp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    enc_ready = 1'b1; xfer_cnt = 0;
    cyc(1);
    feed(63, 1'b0);
    n_checks++;
    if (feat_ready !== 1'b1) $display("FAIL ar_still_warm: got %b want 1", feat_ready);
    else n_pass++;
    feed(1, 1'b0);
    n_checks++;
    if (feat_ready !== 1'b0 || xfer_cnt !== 64) $display("FAIL ar_rewarm: got %b %0d want 0 64", feat_ready, xfer_cnt);
    else n_pass++;
  endtask

`ifdef SCHED_OVERRUN_CNT_EN
  task automatic test_ovr_cnt;
    enc_ready = 1'b0;
    send(64'h1357_9BDF_2468_ACE0, 1'b1);
    for (int k = 0; k < 3; k++) send({$urandom, $urandom}, 1'b0);
    cyc(1);
    n_checks++;
    if (ovr_cnt !== 16'd3) $display("FAIL ovrcnt_3: got %0d want 3", ovr_cnt);
    else n_pass++;
    ovr_clr = 1'b1;
    send({$urandom, $urandom}, 1'b0);
    ovr_clr = 1'b0;
    n_checks++;
    if (ovr_cnt !== 16'd1) $display("FAIL ovrcnt_clr_inc: got %0d want 1", ovr_cnt);
    else n_pass++;
    enc_ready = 1'b1;
    cyc(2);
  endtask
`endif

  initial begin
    test_reset;
    test_warmup;
    test_run_backpressure;
    test_overrun;
    test_back_to_back;
    test_drain;
    test_async_reset;
`ifdef SCHED_OVERRUN_CNT_EN
    test_ovr_cnt;
`endif
    cyc(3);
    n_checks++;
    if (samp_q.size() != 0 || feat_q.size() != 0)
      $display("FAIL scoreboard_leftover: got %0d/%0d want 0/0", samp_q.size(), feat_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
